// File: rtl/line_mem_if.sv
// line_mem_if: request, write-beat and read-beat channels of the line memory.
// The master is the cache controller; the slave is line_mem.
interface line_mem_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] wr_data;
   logic              wr_valid;
   logic              wr_ready;
   logic              wr_done;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic              rd_ready;
   logic              rd_last;

   modport master (
      output req_valid,
      output req_we,
      output req_addr,
      output wr_data,
      output wr_valid,
      output rd_ready,
      input  req_ready,
      input  wr_ready,
      input  wr_done,
      input  rd_data,
      input  rd_valid,
      input  rd_last
   );

   modport slave (
      input  req_valid,
      input  req_we,
      input  req_addr,
      input  wr_data,
      input  wr_valid,
      input  rd_ready,
      output req_ready,
      output wr_ready,
      output wr_done,
      output rd_data,
      output rd_valid,
      output rd_last
   );
endinterface

// File: rtl/line_mem.sv
// line_mem: burst line memory with configurable latency and a
// post-reset clear sweep, serving cache refills and write-backs.
module line_mem #(
   parameter int MEM_WORDS  = 1024,
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 32,
   parameter int LINE_WORDS = 4,
   parameter int LATENCY    = 4
) (
   input  logic       clk,
   input  logic       rst,
   line_mem_if.slave  bus,
   output logic       init_done
);

   localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
   localparam int BW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   localparam logic [AW-1:0] LAST_IDX  = AW'(MEM_WORDS - 1);
   localparam logic [AW-1:0] LINE_MASK = AW'(LINE_WORDS - 1);
   localparam logic [BW-1:0] LAST_BEAT = BW'(LINE_WORDS - 1);
   localparam logic [CW-1:0] LAT_LOAD  =
      CW'((LATENCY > 0) ? LATENCY - 1 : 0);
   localparam logic          LAT0      = (LATENCY == 0);

   typedef enum logic [2:0] {
      INIT,
      IDLE,
      WR_BURST,
      WAIT,
      RD_BURST,
      DONE
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [DATA_W-1:0] mem [MEM_WORDS];

   logic [AW-1:0]     sweep;
   logic [AW-1:0]     base;
   logic [BW-1:0]     beat;
   logic [BW-1:0]     beat_nxt;
   logic [CW-1:0]     lat;
   logic              is_wr;
   logic              done_q;
   logic              init_q;
   logic              rv_q;
   logic              last_q;
   logic [DATA_W-1:0] data_q;
   logic              req_rdy;
   logic              wr_rdy;
   logic              wr_fire;
   logic [AW-1:0]     wr_idx;
   logic [AW-1:0]     rd_idx;
   logic [AW-1:0]     rd_idx_nxt;

   generate
      if (ADDR_W > AW) begin : g_unused_addr
         logic unused_addr;
         assign unused_addr = ^bus.req_addr[ADDR_W-1:AW];
      end
   endgenerate

   assign beat_nxt   = (beat == LAST_BEAT) ? '0 : beat + BW'(1);
   assign wr_fire    = (state == WR_BURST) && bus.wr_valid;
   assign wr_idx     = base + AW'(beat);
   assign rd_idx     = base + AW'(beat);
   assign rd_idx_nxt = base + AW'(beat_nxt);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= INIT;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      req_rdy   = 1'b0;
      wr_rdy    = 1'b0;
      unique case (state)
         INIT: begin
            if (sweep == LAST_IDX) begin
               state_nxt = IDLE;
            end
         end
         IDLE: begin
            req_rdy = 1'b1;
            if (bus.req_valid) begin
               if (bus.req_we) begin
                  state_nxt = WR_BURST;
               end else begin
                  state_nxt = LAT0 ? RD_BURST : WAIT;
               end
            end
         end
         WR_BURST: begin
            wr_rdy = 1'b1;
            if (bus.wr_valid && (beat == LAST_BEAT)) begin
               state_nxt = LAT0 ? DONE : WAIT;
            end
         end
         WAIT: begin
            if (lat == '0) begin
               state_nxt = is_wr ? DONE : RD_BURST;
            end
         end
         DONE: begin
            if (done_q) begin
               state_nxt = IDLE;
            end
         end
         RD_BURST: begin
            if (rv_q && bus.rd_ready && last_q) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = INIT;
      endcase
   end

   // Storage has no reset; the sweep clears it instead.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state == INIT) begin
            mem[sweep] <= '0;
         end else if (wr_fire) begin
            mem[wr_idx] <= bus.wr_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sweep  <= '0;
         init_q <= 1'b0;
         base   <= '0;
         beat   <= '0;
         lat    <= '0;
         is_wr  <= 1'b0;
         done_q <= 1'b0;
         rv_q   <= 1'b0;
         last_q <= 1'b0;
         data_q <= '0;
      end else begin
         unique case (state)
            INIT: begin
               sweep <= sweep + AW'(1);
               if (sweep == LAST_IDX) begin
                  init_q <= 1'b1;
               end
            end
            IDLE: begin
               if (bus.req_valid) begin
                  is_wr <= bus.req_we;
                  base  <= bus.req_addr[AW-1:0] & ~LINE_MASK;
                  beat  <= '0;
                  lat   <= LAT_LOAD;
               end
            end
            WR_BURST: begin
               if (bus.wr_valid) begin
                  beat <= beat_nxt;
                  lat  <= LAT_LOAD;
               end
            end
            WAIT: begin
               if (lat != '0) begin
                  lat <= lat - CW'(1);
               end
            end
            DONE: begin
               // first cycle arms the pulse, second cycle shows it
               done_q <= ~done_q;
            end
            RD_BURST: begin
               if (!rv_q) begin
                  rv_q   <= 1'b1;
                  data_q <= mem[rd_idx];
                  last_q <= (beat == LAST_BEAT);
               end else if (bus.rd_ready) begin
                  if (last_q) begin
                     rv_q   <= 1'b0;
                     last_q <= 1'b0;
                     beat   <= '0;
                  end else begin
                     beat   <= beat_nxt;
                     data_q <= mem[rd_idx_nxt];
                     last_q <= (beat_nxt == LAST_BEAT);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.req_ready = req_rdy;
   assign bus.wr_ready  = wr_rdy;
   assign bus.wr_done   = done_q;
   assign bus.rd_valid  = rv_q;
   assign bus.rd_last   = last_q;
   assign bus.rd_data   = data_q;
   assign init_done     = init_q;

endmodule

// File: tb/tb_line_mem.sv
// tb_line_mem: directed scenarios for line_mem, one task per feature.
// dut0 is the default build; dut1 is a small zero-latency build.
module tb_line_mem;

   localparam logic [127:0] LA =
      {32'hAAAA0003, 32'hAAAA0002, 32'hAAAA0001, 32'hAAAA0000};
   localparam logic [127:0] LB =
      {32'hBBBB0003, 32'hBBBB0002, 32'hBBBB0001, 32'hBBBB0000};
   localparam logic [127:0] LC =
      {32'hCCCC0003, 32'hCCCC0002, 32'hCCCC0001, 32'hCCCC0000};
   localparam logic [127:0] LD =
      {32'hDDDD0003, 32'hDDDD0002, 32'hDDDD0001, 32'hDDDD0000};
   localparam logic [127:0] LE =
      {32'hEEEE0003, 32'hEEEE0002, 32'hEEEE0001, 32'hEEEE0000};
   localparam logic [127:0] LF =
      {32'hF0F00003, 32'hF0F00002, 32'hF0F00001, 32'hF0F00000};

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sel = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_we = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] wr_data = '0;
   logic        wr_valid = 1'b0;
   logic        rd_ready = 1'b1;
   logic        init0;
   logic        init1;

   int n_checks = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   line_mem_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();
   line_mem_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();

   assign bus0.req_valid = req_valid & ~sel;
   assign bus0.req_we    = req_we;
   assign bus0.req_addr  = req_addr;
   assign bus0.wr_data   = wr_data;
   assign bus0.wr_valid  = wr_valid & ~sel;
   assign bus0.rd_ready  = rd_ready;
   assign bus1.req_valid = req_valid & sel;
   assign bus1.req_we    = req_we;
   assign bus1.req_addr  = req_addr;
   assign bus1.wr_data   = wr_data;
   assign bus1.wr_valid  = wr_valid & sel;
   assign bus1.rd_ready  = rd_ready;

   wire        o_req_ready = sel ? bus1.req_ready : bus0.req_ready;
   wire        o_wr_ready  = sel ? bus1.wr_ready : bus0.wr_ready;
   wire        o_wr_done   = sel ? bus1.wr_done : bus0.wr_done;
   wire        o_rd_valid  = sel ? bus1.rd_valid : bus0.rd_valid;
   wire        o_rd_last   = sel ? bus1.rd_last : bus0.rd_last;
   wire [31:0] o_rd_data   = sel ? bus1.rd_data : bus0.rd_data;

   line_mem #(
      .MEM_WORDS(1024), .DATA_W(32), .ADDR_W(32),
      .LINE_WORDS(4), .LATENCY(4)
   ) dut0 (
      .clk(clk), .rst(rst), .bus(bus0), .init_done(init0)
   );

   line_mem #(
      .MEM_WORDS(64), .DATA_W(32), .ADDR_W(32),
      .LINE_WORDS(4), .LATENCY(0)
   ) dut1 (
      .clk(clk), .rst(rst), .bus(bus1), .init_done(init1)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (!o_req_ready && n < 2000) begin
         tick();
         n++;
      end
   endtask

   task automatic do_write(
      input  logic [31:0]  addr,
      input  logic [127:0] line,
      input  logic [15:0]  gaps,
      output int           lat,
      output logic         bad_rdy,
      output logic         req_at_done,
      output logic         done_after,
      output logic         req_after
   );
      int n;
      wait_ready();
      bad_rdy = 1'b0;
      req_valid = 1'b1;
      req_we = 1'b1;
      req_addr = addr;
      tick();
      req_valid = 1'b0;
      req_we = 1'b0;
      for (int k = 0; k < 4; k++) begin
         for (int g = 0; g < int'(gaps[4*k +: 4]); g++) begin
            wr_valid = 1'b0;
            tick();
         end
         wr_valid = 1'b1;
         wr_data = line[32*k +: 32];
         if (!o_wr_ready) bad_rdy = 1'b1;
         tick();
      end
      wr_valid = 1'b0;
      n = 0;
      do begin
         tick();
         n++;
      end while (!o_wr_done && n < 100);
      lat = o_wr_done ? n : -1;
      req_at_done = o_req_ready;
      tick();
      done_after = o_wr_done;
      req_after = o_req_ready;
   endtask

   task automatic do_read(
      input  logic [31:0]  addr,
      input  logic [15:0]  stalls,
      output int           lat,
      output logic [127:0] line,
      output logic [3:0]   lasts,
      output int           vcyc,
      output logic         stable,
      output logic         req_after
   );
      int n;
      logic [31:0] hd;
      logic hl;
      wait_ready();
      rd_ready = 1'b1;
      req_valid = 1'b1;
      req_we = 1'b0;
      req_addr = addr;
      tick();
      req_valid = 1'b0;
      n = 0;
      do begin
         tick();
         n++;
      end while (!o_rd_valid && n < 100);
      lat = o_rd_valid ? n : -1;
      stable = 1'b1;
      vcyc = 0;
      line = '0;
      lasts = '0;
      for (int k = 0; k < 4; k++) begin
         hd = o_rd_data;
         hl = o_rd_last;
         for (int s = 0; s < int'(stalls[4*k +: 4]); s++) begin
            rd_ready = 1'b0;
            if (o_rd_valid) vcyc++;
            if (o_rd_data !== hd || o_rd_last !== hl) stable = 1'b0;
            tick();
         end
         if (o_rd_data !== hd || o_rd_last !== hl) stable = 1'b0;
         rd_ready = 1'b1;
         if (o_rd_valid) vcyc++;
         line[32*k +: 32] = o_rd_data;
         lasts[k] = o_rd_last & o_rd_valid;
         tick();
      end
      req_after = o_req_ready & ~o_rd_valid;
   endtask

   task automatic test_reset();
      int n;
      sel = 1'b0;
      rst = 1'b1;
      tick();
      tick();
      n_checks++;
      if ({o_req_ready, o_wr_ready, o_wr_done} !== 3'b000) begin
         n_err++;
         $display("FAIL reset_ctl: got %b want 000",
                  {o_req_ready, o_wr_ready, o_wr_done});
      end
      n_checks++;
      if ({o_rd_valid, o_rd_last, init0} !== 3'b000) begin
         n_err++;
         $display("FAIL reset_rd: got %b want 000",
                  {o_rd_valid, o_rd_last, init0});
      end
      n_checks++;
      if (o_rd_data !== 32'h0) begin
         n_err++;
         $display("FAIL reset_data: got %h want 0", o_rd_data);
      end
      rst = 1'b0;
      n = 0;
      do begin
         tick();
         n++;
      end while (!init0 && n < 3000);
      n_checks++;
      if (n !== 1024) begin
         n_err++;
         $display("FAIL init_cycles: got %0d want 1024", n);
      end
      n_checks++;
      if (o_req_ready !== 1'b1 || init1 !== 1'b1) begin
         n_err++;
         $display("FAIL init_ready: got %b want 11",
                  {o_req_ready, init1});
      end
   endtask

   task automatic test_write_read();
      int lat, vcyc;
      logic bad, rqd, dna, rqa, stb;
      logic [127:0] line;
      logic [3:0] lasts;
      do_write(32'h10, LA, 16'h0, lat, bad, rqd, dna, rqa);
      n_checks++;
      if (lat !== 5) begin
         n_err++;
         $display("FAIL wr_latency: got %0d want 5", lat);
      end
      n_checks++;
      if ({bad, rqd, dna, rqa} !== 4'b0001) begin
         n_err++;
         $display("FAIL wr_handshake: got %b want 0001",
                  {bad, rqd, dna, rqa});
      end
      do_read(32'h12, 16'h0, lat, line, lasts, vcyc, stb, rqa);
      n_checks++;
      if (lat !== 5) begin
         n_err++;
         $display("FAIL rd_latency: got %0d want 5", lat);
      end
      n_checks++;
      if (line !== LA) begin
         n_err++;
         $display("FAIL rd_data: got %h want %h", line, LA);
      end
      n_checks++;
      if (lasts !== 4'b1000 || vcyc !== 4 || rqa !== 1'b1) begin
         n_err++;
         $display("FAIL rd_burst: got last=%b v=%0d rdy=%b want 1000 4 1",
                  lasts, vcyc, rqa);
      end
   endtask

   task automatic test_backpressure();
      int lat, vcyc;
      logic bad, rqd, dna, rqa, stb;
      logic [127:0] line;
      logic [3:0] lasts;
      do_write(32'h40, LB, 16'h2020, lat, bad, rqd, dna, rqa);
      n_checks++;
      if (lat !== 5 || bad !== 1'b0) begin
         n_err++;
         $display("FAIL bp_write: got lat=%0d bad=%b want 5 0", lat, bad);
      end
      do_read(32'h40, 16'h0330, lat, line, lasts, vcyc, stb, rqa);
      n_checks++;
      if (line !== LB) begin
         n_err++;
         $display("FAIL bp_data: got %h want %h", line, LB);
      end
      n_checks++;
      if (stb !== 1'b1) begin
         n_err++;
         $display("FAIL bp_stable: got %b want 1", stb);
      end
      n_checks++;
      if (vcyc !== 10 || lasts !== 4'b1000) begin
         n_err++;
         $display("FAIL bp_cycles: got v=%0d last=%b want 10 1000",
                  vcyc, lasts);
      end
   endtask

   task automatic test_wrap();
      int lat, vcyc;
      logic bad, rqd, dna, rqa, stb;
      logic [127:0] line;
      logic [3:0] lasts;
      do_write(32'd1027, LC, 16'h0, lat, bad, rqd, dna, rqa);
      do_read(32'd3, 16'h0, lat, line, lasts, vcyc, stb, rqa);
      n_checks++;
      if (line !== LC) begin
         n_err++;
         $display("FAIL wrap_read: got %h want %h", line, LC);
      end
      do_read(32'h10, 16'h0, lat, line, lasts, vcyc, stb, rqa);
      n_checks++;
      if (line !== LA) begin
         n_err++;
         $display("FAIL wrap_neighbour: got %h want %h", line, LA);
      end
   endtask

   task automatic test_reset_mid_read();
      int n, lat, vcyc;
      logic seen, stb, rqa;
      logic [127:0] line;
      logic [3:0] lasts;
      wait_ready();
      rd_ready = 1'b1;
      req_valid = 1'b1;
      req_we = 1'b0;
      req_addr = 32'h40;
      tick();
      req_valid = 1'b0;
      n = 0;
      do begin
         tick();
         n++;
      end while (!o_rd_valid && n < 100);
      tick();
      tick();
      n_checks++;
      if (o_rd_data !== LB[95:64] || o_rd_last !== 1'b0) begin
         n_err++;
         $display("FAIL mid_beat2: got %h/%b want %h/0",
                  o_rd_data, o_rd_last, LB[95:64]);
      end
      rst = 1'b1;
      tick();
      n_checks++;
      if ({o_rd_valid, o_rd_last, o_req_ready, init0} !== 4'b0000) begin
         n_err++;
         $display("FAIL mid_abort: got %b want 0000",
                  {o_rd_valid, o_rd_last, o_req_ready, init0});
      end
      rst = 1'b0;
      seen = 1'b0;
      n = 0;
      do begin
         tick();
         n++;
         if (o_rd_valid || o_rd_last) seen = 1'b1;
      end while (!init0 && n < 3000);
      n_checks++;
      if (n !== 1024 || seen !== 1'b0) begin
         n_err++;
         $display("FAIL mid_sweep: got n=%0d seen=%b want 1024 0", n, seen);
      end
      do_read(32'h40, 16'h0, lat, line, lasts, vcyc, stb, rqa);
      n_checks++;
      if (line !== 128'h0) begin
         n_err++;
         $display("FAIL mid_cleared: got %h want 0", line);
      end
   endtask

   task automatic test_reset_sweep();
      int n, lat, vcyc;
      logic bad, rqd, dna, rqa, stb;
      logic [127:0] line;
      logic [3:0] lasts;
      do_write(32'h20, LD, 16'h0, lat, bad, rqd, dna, rqa);
      do_read(32'h20, 16'h0, lat, line, lasts, vcyc, stb, rqa);
      n_checks++;
      if (line !== LD) begin
         n_err++;
         $display("FAIL preload: got %h want %h", line, LD);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n = 0;
      do begin
         tick();
         n++;
      end while (!(init0 && o_req_ready) && n < 3000);
      n_checks++;
      if (n !== 1024) begin
         n_err++;
         $display("FAIL sweep_cycles: got %0d want 1024", n);
      end
      do_read(32'h20, 16'h0, lat, line, lasts, vcyc, stb, rqa);
      n_checks++;
      if (line !== 128'h0) begin
         n_err++;
         $display("FAIL sweep_clear: got %h want 0", line);
      end
      do_read(32'h3, 16'h0, lat, line, lasts, vcyc, stb, rqa);
      n_checks++;
      if (line !== 128'h0) begin
         n_err++;
         $display("FAIL sweep_clear0: got %h want 0", line);
      end
   endtask

   task automatic test_zero_latency();
      int lat, vcyc;
      logic bad, rqd, dna, rqa, stb;
      logic [127:0] line;
      logic [3:0] lasts;
      sel = 1'b1;
      do_write(32'h8, LE, 16'h0, lat, bad, rqd, dna, rqa);
      n_checks++;
      if (lat !== 1 || {bad, rqd, dna, rqa} !== 4'b0001) begin
         n_err++;
         $display("FAIL z_write: got lat=%0d hs=%b want 1 0001",
                  lat, {bad, rqd, dna, rqa});
      end
      do_read(32'h9, 16'h0, lat, line, lasts, vcyc, stb, rqa);
      n_checks++;
      if (lat !== 1) begin
         n_err++;
         $display("FAIL z_rd_latency: got %0d want 1", lat);
      end
      n_checks++;
      if (line !== LE || lasts !== 4'b1000 || vcyc !== 4) begin
         n_err++;
         $display("FAIL z_rd_data: got %h %b %0d want %h 1000 4",
                  line, lasts, vcyc, LE);
      end
      do_write(32'd67, LF, 16'h0101, lat, bad, rqd, dna, rqa);
      do_read(32'h0, 16'h0, lat, line, lasts, vcyc, stb, rqa);
      n_checks++;
      if (line !== LF) begin
         n_err++;
         $display("FAIL z_wrap: got %h want %h", line, LF);
      end
      sel = 1'b0;
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_backpressure();
      test_wrap();
      test_reset_mid_read();
      test_reset_sweep();
      test_zero_latency();
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
